// File: rtl/mem_pkg.sv
// Shared encodings for the MEM/WB segment: access sizes, handshake FSM states
// and the byte-enable mask helper.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    logic [7:0] m;
    case (sz)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load result formatting: shift the addressed bytes down to bit 0, then
// sign- or zero-extend from the access size to the full datapath width.
module mem_load_ext
  import mem_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OFS  = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0] i_rdata,
  input  logic [OFS-1:0]  i_ofs,
  input  logic [1:0]      i_size,
  input  logic            i_uns,
  output logic [XLEN-1:0] o_data
);

  logic [XLEN-1:0] w_shift;
  logic [XLEN-1:0] w_mask;
  logic            w_sign;

  assign w_shift = i_rdata >> {i_ofs, 3'b000};

  // Mask and sign bit follow the access size; D covers the whole word.
  always_comb begin
    w_mask = '1;
    w_sign = 1'b0;
    case (i_size)
      SZ_B: begin
        w_mask = XLEN'(64'h0000_0000_0000_00FF);
        w_sign = w_shift[7];
      end
      SZ_H: begin
        w_mask = XLEN'(64'h0000_0000_0000_FFFF);
        w_sign = w_shift[15];
      end
      SZ_W: begin
        w_mask = XLEN'(64'h0000_0000_FFFF_FFFF);
        w_sign = w_shift[31];
      end
      default: begin
        w_mask = '1;
        w_sign = w_shift[XLEN-1];
      end
    endcase
  end

  assign o_data = i_uns ? (w_shift & w_mask)
                        : ((w_shift & w_mask) | (w_sign ? ~w_mask : '0));

endmodule

// File: rtl/mem_wb_seg_hs.sv
// MEM/WB pipeline segment with a req/gnt/rvalid data-memory handshake.
// Stores are posted on grant; loads stall the pipe until rvalid.
module mem_wb_seg_hs
  import mem_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                clear,
  input  logic [XLEN-1:0]     AluOutE,
  input  logic [XLEN-1:0]     StoreDataE,
  input  logic [4:0]          RdE,
  input  logic [ADDR_W-1:0]   PCE,
  input  logic                MemReadE,
  input  logic                MemWriteE,
  input  logic [1:0]          MemSizeE,
  input  logic                LoadUnsE,
  input  logic                RegWriteE,
  input  logic                MemToRegE,
  input  logic                LoadNpcE,
  output logic                MemReq,
  output logic                MemWe,
  output logic [ADDR_W-1:0]   MemAddr,
  output logic [XLEN/8-1:0]   MemBe,
  output logic [XLEN-1:0]     MemWdata,
  input  logic                MemGnt,
  input  logic                MemRvalid,
  input  logic [XLEN-1:0]     MemRdata,
  output logic                StallMW,
  output logic [XLEN-1:0]     AluOutMW,
  output logic [4:0]          RdMW,
  output logic [ADDR_W-1:0]   PCMW,
  output logic                RegWriteMW,
  output logic                MemToRegMW,
  output logic                LoadNpcMW,
  output logic [XLEN-1:0]     LoadDataMW,
  output logic                MisalignMW
);

  localparam int NB  = XLEN / 8;
  localparam int OFS = $clog2(NB);

  state_t          r_state;
  logic [ADDR_W-1:0] w_addr;
  logic [OFS-1:0]  w_ofs;
  logic            w_acc;
  logic            w_align_err;
  logic            w_mis;
  logic            w_req_idle;
  logic            w_done;
  logic [XLEN-1:0] w_ext;

  assign w_addr = ADDR_W'(AluOutE);
  assign w_ofs  = w_addr[OFS-1:0];
  assign w_acc  = MemReadE | MemWriteE;

  assign w_align_err = ((MemSizeE == SZ_H) & w_addr[0])
                     | ((MemSizeE == SZ_W) & (|w_addr[1:0]))
                     | ((MemSizeE == SZ_D) & ((|w_addr[2:0]) | (XLEN == 32)));
  assign w_mis       = w_acc & w_align_err;
  assign w_req_idle  = w_acc & ~w_mis & en & ~clear;

  assign MemAddr  = {w_addr[ADDR_W-1:OFS], {OFS{1'b0}}};
  assign MemBe    = NB'(size_mask(MemSizeE)) << w_ofs;
  assign MemWdata = StoreDataE << {w_ofs, 3'b000};
  assign MemWe    = MemReq & MemWriteE;

  // Once in REQ the access is committed, so en/clear no longer withdraw it.
  always_comb begin
    MemReq  = 1'b0;
    StallMW = 1'b0;
    case (r_state)
      ST_IDLE: begin
        MemReq  = w_req_idle;
        StallMW = w_req_idle & ~(MemWriteE & MemGnt);
      end
      ST_REQ: begin
        MemReq  = w_acc & ~w_mis;
        StallMW = ~(MemWriteE & MemGnt);
      end
      ST_RESP: begin
        MemReq  = 1'b0;
        StallMW = ~MemRvalid;
      end
      default: begin
        MemReq  = 1'b0;
        StallMW = 1'b0;
      end
    endcase
  end

  assign w_done = ((r_state == ST_REQ) & MemGnt & MemWriteE)
                | ((r_state == ST_RESP) & MemRvalid);

  mem_load_ext #(.XLEN(XLEN), .OFS(OFS)) u_ext (
    .i_rdata (MemRdata),
    .i_ofs   (w_ofs),
    .i_size  (MemSizeE),
    .i_uns   (LoadUnsE),
    .o_data  (w_ext)
  );

  // Handshake FSM; rvalid outside RESP is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_idle) begin
            if (!MemGnt)        r_state <= ST_REQ;
            else if (!MemWriteE) r_state <= ST_RESP;
            else                r_state <= ST_IDLE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (MemGnt) r_state <= MemWriteE ? ST_IDLE : ST_RESP;
          else        r_state <= ST_REQ;
        end
        ST_RESP: begin
          if (MemRvalid) r_state <= ST_IDLE;
          else           r_state <= ST_RESP;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // MW register: bubble while stalled or flushed, capture on advance/completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      AluOutMW   <= '0;
      RdMW       <= 5'd0;
      PCMW       <= '0;
      RegWriteMW <= 1'b0;
      MemToRegMW <= 1'b0;
      LoadNpcMW  <= 1'b0;
      LoadDataMW <= '0;
      MisalignMW <= 1'b0;
    end else if (StallMW || ((r_state == ST_IDLE) && en && clear)) begin
      AluOutMW   <= '0;
      RdMW       <= 5'd0;
      PCMW       <= '0;
      RegWriteMW <= 1'b0;
      MemToRegMW <= 1'b0;
      LoadNpcMW  <= 1'b0;
      LoadDataMW <= '0;
      MisalignMW <= 1'b0;
    end else if (w_done || ((r_state == ST_IDLE) && en)) begin
      AluOutMW   <= AluOutE;
      RdMW       <= RdE;
      PCMW       <= PCE;
      RegWriteMW <= RegWriteE & ~w_mis;
      MemToRegMW <= MemToRegE;
      LoadNpcMW  <= LoadNpcE;
      LoadDataMW <= (r_state == ST_RESP) ? w_ext : '0;
      MisalignMW <= w_mis;
    end
  end

endmodule

// File: tb/tb_mem_wb_seg_hs.sv
// Directed bench for mem_wb_seg_hs: a 32-bit instance for the main sequence
// and a 64-bit instance for doubleword and upper-lane load cases.
module tb_mem_wb_seg_hs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, clear;
  logic [31:0] AluOutE, StoreDataE, PCE, MemAddr, MemWdata, MemRdata;
  logic [31:0] AluOutMW, PCMW, LoadDataMW;
  logic [4:0]  RdE, RdMW;
  logic        MemReadE, MemWriteE, LoadUnsE, RegWriteE, MemToRegE, LoadNpcE;
  logic        MemReq, MemWe, MemGnt, MemRvalid, StallMW;
  logic        RegWriteMW, MemToRegMW, LoadNpcMW, MisalignMW;
  logic [1:0]  MemSizeE;
  logic [3:0]  MemBe;

  logic [63:0] a64, sd64, wd64, rdat64, alu64_mw, ld64_mw;
  logic [31:0] addr64, pc64_mw;
  logic [4:0]  rd64_mw;
  logic [7:0]  be64;
  logic [1:0]  sz64;
  logic        rd64_e, wr64_e, req64, we64, gnt64, rvalid64, stall64;
  logic        rw64_mw, m2r64_mw, npc64_mw, mis64_mw;

  int n_vec = 0;
  int n_err = 0;

  mem_wb_seg_hs #(.XLEN(32), .ADDR_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear),
    .AluOutE(AluOutE), .StoreDataE(StoreDataE), .RdE(RdE), .PCE(PCE),
    .MemReadE(MemReadE), .MemWriteE(MemWriteE), .MemSizeE(MemSizeE),
    .LoadUnsE(LoadUnsE), .RegWriteE(RegWriteE), .MemToRegE(MemToRegE),
    .LoadNpcE(LoadNpcE), .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr),
    .MemBe(MemBe), .MemWdata(MemWdata), .MemGnt(MemGnt), .MemRvalid(MemRvalid),
    .MemRdata(MemRdata), .StallMW(StallMW), .AluOutMW(AluOutMW), .RdMW(RdMW),
    .PCMW(PCMW), .RegWriteMW(RegWriteMW), .MemToRegMW(MemToRegMW),
    .LoadNpcMW(LoadNpcMW), .LoadDataMW(LoadDataMW), .MisalignMW(MisalignMW)
  );

  mem_wb_seg_hs #(.XLEN(64), .ADDR_W(32)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear),
    .AluOutE(a64), .StoreDataE(sd64), .RdE(RdE), .PCE(PCE),
    .MemReadE(rd64_e), .MemWriteE(wr64_e), .MemSizeE(sz64),
    .LoadUnsE(1'b0), .RegWriteE(RegWriteE), .MemToRegE(MemToRegE),
    .LoadNpcE(LoadNpcE), .MemReq(req64), .MemWe(we64), .MemAddr(addr64),
    .MemBe(be64), .MemWdata(wd64), .MemGnt(gnt64), .MemRvalid(rvalid64),
    .MemRdata(rdat64), .StallMW(stall64), .AluOutMW(alu64_mw), .RdMW(rd64_mw),
    .PCMW(pc64_mw), .RegWriteMW(rw64_mw), .MemToRegMW(m2r64_mw),
    .LoadNpcMW(npc64_mw), .LoadDataMW(ld64_mw), .MisalignMW(mis64_mw)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    en = 1'b1; clear = 1'b0;
    AluOutE = 32'd0; StoreDataE = 32'd0; RdE = 5'd0; PCE = 32'd0;
    MemReadE = 1'b0; MemWriteE = 1'b0; MemSizeE = 2'b00; LoadUnsE = 1'b0;
    RegWriteE = 1'b0; MemToRegE = 1'b0; LoadNpcE = 1'b0;
    MemGnt = 1'b0; MemRvalid = 1'b0; MemRdata = 32'd0;
    a64 = 64'd0; sd64 = 64'd0; rd64_e = 1'b0; wr64_e = 1'b0; sz64 = 2'b00;
    gnt64 = 1'b0; rvalid64 = 1'b0; rdat64 = 64'd0;
  endtask

  // Load with gnt in cycle gc, rvalid in cycle rc (> gc), clear pulsed in cycle cc.
  task automatic run_load(input string tag, input logic [31:0] addr, input logic [1:0] sz,
                          input logic uns, input int gc, input int rc, input int cc,
                          input logic [31:0] rdata, input logic [31:0] exp);
    AluOutE = addr; MemReadE = 1'b1; MemSizeE = sz; LoadUnsE = uns;
    RegWriteE = 1'b1; MemToRegE = 1'b1; RdE = 5'd7; MemRdata = rdata;
    for (int c = 0; c <= rc; c++) begin
      MemGnt = (c == gc); MemRvalid = (c == rc); clear = (c == cc);
      #1;
      chk({tag, "_stall"}, 64'(StallMW), 64'(c < rc));
      chk({tag, "_req"}, 64'(MemReq), 64'(c <= gc));
      @(posedge clk); #1;
      if (c < rc) chk({tag, "_bubble"}, 64'(RegWriteMW), 64'd0);
    end
    chk({tag, "_data"}, 64'(LoadDataMW), 64'(exp));
    chk({tag, "_rw"}, 64'(RegWriteMW), 64'd1);
    chk({tag, "_rd"}, 64'(RdMW), 64'd7);
    idle();
  endtask

  // 64-bit load, granted at once, response one cycle later.
  task automatic run_load64(input string tag, input logic [63:0] addr, input logic [1:0] sz,
                            input logic [7:0] be_exp, input logic [63:0] rdata,
                            input logic [63:0] exp);
    a64 = addr; rd64_e = 1'b1; sz64 = sz; gnt64 = 1'b1;
    #1;
    chk({tag, "_req"}, 64'(req64), 64'd1);
    chk({tag, "_be"}, 64'(be64), 64'(be_exp));
    chk({tag, "_addr"}, 64'(addr64), addr & 64'hFFFF_FFF8);
    @(posedge clk); #1;
    gnt64 = 1'b0; rvalid64 = 1'b1; rdat64 = rdata;
    #1;
    chk({tag, "_stall"}, 64'(stall64), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_data"}, ld64_mw, exp);
    idle();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_alu", 64'(AluOutMW), 64'd0);
    chk("rst_rw", 64'(RegWriteMW), 64'd0);
    chk("rst_ld", 64'(LoadDataMW), 64'd0);
    chk("rst_mis", 64'(MisalignMW), 64'd0);
    chk("rst_req", 64'(MemReq), 64'd0);
    chk("rst_stall", 64'(StallMW), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ALU op
    AluOutE = 32'h1234; RdE = 5'd5; RegWriteE = 1'b1; PCE = 32'h100;
    #1;
    chk("alu_stall", 64'(StallMW), 64'd0);
    chk("alu_req", 64'(MemReq), 64'd0);
    @(posedge clk); #1;
    chk("alu_out", 64'(AluOutMW), 64'h1234);
    chk("alu_rd", 64'(RdMW), 64'd5);
    chk("alu_rw", 64'(RegWriteMW), 64'd1);
    chk("alu_pc", 64'(PCMW), 64'h100);
    idle();

    // SB posted with immediate grant
    AluOutE = 32'h103; StoreDataE = 32'hAB; MemWriteE = 1'b1; MemSizeE = 2'b00; MemGnt = 1'b1;
    #1;
    chk("sb_req", 64'(MemReq), 64'd1);
    chk("sb_we", 64'(MemWe), 64'd1);
    chk("sb_addr", 64'(MemAddr), 64'h100);
    chk("sb_be", 64'(MemBe), 64'b1000);
    chk("sb_wdata", 64'(MemWdata), 64'hAB00_0000);
    chk("sb_stall", 64'(StallMW), 64'd0);
    @(posedge clk); #1;
    chk("sb_alu", 64'(AluOutMW), 64'h103);
    idle();

    // SH at 0x102 with grant one cycle late
    AluOutE = 32'h102; StoreDataE = 32'h1234; MemWriteE = 1'b1; MemSizeE = 2'b01;
    #1;
    chk("sh_be", 64'(MemBe), 64'b1100);
    chk("sh_wdata", 64'(MemWdata), 64'h1234_0000);
    chk("sh_stall0", 64'(StallMW), 64'd1);
    @(posedge clk); #1;
    MemGnt = 1'b1;
    #1;
    chk("sh_req1", 64'(MemReq), 64'd1);
    chk("sh_stall1", 64'(StallMW), 64'd0);
    @(posedge clk); #1;
    chk("sh_alu", 64'(AluOutMW), 64'h102);
    idle();

    run_load("lb_s", 32'h101, 2'b00, 1'b0, 2, 5, -1, 32'h0000_80FF, 32'hFFFF_FF80);
    run_load("lb_u", 32'h101, 2'b00, 1'b1, 0, 1, -1, 32'h0000_80FF, 32'h0000_0080);
    run_load("lh_clr", 32'h102, 2'b01, 1'b0, 0, 3, 1, 32'h8001_0000, 32'hFFFF_8001);

    // Misaligned LW traps without a bus request
    AluOutE = 32'h102; MemReadE = 1'b1; MemSizeE = 2'b10; RegWriteE = 1'b1;
    #1;
    chk("mis_req", 64'(MemReq), 64'd0);
    chk("mis_stall", 64'(StallMW), 64'd0);
    @(posedge clk); #1;
    chk("mis_flag", 64'(MisalignMW), 64'd1);
    chk("mis_rw", 64'(RegWriteMW), 64'd0);
    idle();

    // en=0 holds, then clear loads a bubble
    AluOutE = 32'h5555; RegWriteE = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    chk("hold_alu", 64'(AluOutMW), 64'h102);
    chk("hold_mis", 64'(MisalignMW), 64'd1);
    en = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    chk("clr_rw", 64'(RegWriteMW), 64'd0);
    idle();

    // Reset while a load is in RESP; later rvalid is ignored
    AluOutE = 32'h0; MemReadE = 1'b1; MemSizeE = 2'b01; RegWriteE = 1'b1; MemGnt = 1'b1;
    @(posedge clk); #1;
    MemGnt = 1'b0;
    #1;
    chk("rr_resp_stall", 64'(StallMW), 64'd1);
    idle();
    rst_n = 1'b0;
    #1;
    chk("rr_req", 64'(MemReq), 64'd0);
    chk("rr_stall", 64'(StallMW), 64'd0);
    chk("rr_rw", 64'(RegWriteMW), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    MemRvalid = 1'b1; MemRdata = 32'hFFFF_FFFF; MemSizeE = 2'b01;
    #1;
    chk("stale_stall", 64'(StallMW), 64'd0);
    @(posedge clk); #1;
    chk("stale_ld", 64'(LoadDataMW), 64'd0);
    chk("stale_rw", 64'(RegWriteMW), 64'd0);
    idle();

    run_load64("ld64", 64'h8, 2'b11, 8'hFF, 64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788);
    run_load64("lw64", 64'hC, 2'b10, 8'hF0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
